// File: rtl/clks_alot_half_rate_meter_pkg.sv
// Shared types and widths for the half-rate meter: FSM state, event/limit/rate
// structs, accumulator width and the averaging-depth clamp.
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH    = 32;
    localparam int MAX_AVG_DEPTH_WIDTH   = 10;
    localparam int RATE_ACC_WIDTH        = RATE_COUNTER_WIDTH + MAX_AVG_DEPTH_WIDTH;
    localparam int AVG_DEPTH_FIELD_WIDTH = 4;
    localparam int SAMPLE_CNT_WIDTH      = MAX_AVG_DEPTH_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meter_state_e;

    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
    } recovered_events_s;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0]    minimum_band_minus_one;
        logic [RATE_COUNTER_WIDTH-1:0]    maximum_band_minus_one;
        logic [AVG_DEPTH_FIELD_WIDTH-1:0] rate_averaging_depth;
    } half_rate_limits_s;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0] high_rate;
        logic [RATE_COUNTER_WIDTH-1:0] low_rate;
        logic                          over_frequency_violation;
        logic                          under_frequency_violation;
    } recovered_half_rates_s;

    // Depth is log2 of the block length; anything beyond the accumulator headroom is clamped.
    function automatic logic [AVG_DEPTH_FIELD_WIDTH-1:0] clamp_depth(
        input logic [AVG_DEPTH_FIELD_WIDTH-1:0] depth
    );
        if (depth > AVG_DEPTH_FIELD_WIDTH'(MAX_AVG_DEPTH_WIDTH))
            return AVG_DEPTH_FIELD_WIDTH'(MAX_AVG_DEPTH_WIDTH);
        return depth;
    endfunction

endpackage

// File: rtl/clks_alot_half_rate_meter_averager.sv
// Block averager for one phase: sums 2^depth samples, emits sum >> depth, then restarts.
// A depth change restarts the block at the sample where it is first seen.
module clks_alot_rate_averager
    import clks_alot_p::*;
(
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic                             clear,
    input  logic                             sample_valid,
    input  logic [RATE_COUNTER_WIDTH-1:0]    sample,
    input  logic [AVG_DEPTH_FIELD_WIDTH-1:0] depth,
    output logic                             avg_valid,
    output logic [RATE_COUNTER_WIDTH-1:0]    avg_value
);

    localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_ONE = SAMPLE_CNT_WIDTH'(1);

    logic [AVG_DEPTH_FIELD_WIDTH-1:0] depth_eff;
    logic [AVG_DEPTH_FIELD_WIDTH-1:0] depth_last;
    logic [RATE_ACC_WIDTH-1:0]        acc;
    logic [RATE_ACC_WIDTH-1:0]        acc_sum;
    logic [SAMPLE_CNT_WIDTH-1:0]      sample_cnt;
    logic [SAMPLE_CNT_WIDTH-1:0]      cnt_next;
    logic [SAMPLE_CNT_WIDTH-1:0]      block_len;
    logic                             restart;
    logic                             block_done;

    always_comb begin
        depth_eff  = clamp_depth(depth);
        restart    = (depth_eff != depth_last);
        acc_sum    = (restart ? '0 : acc) + RATE_ACC_WIDTH'(sample);
        cnt_next   = (restart ? '0 : sample_cnt) + CNT_ONE;
        block_len  = CNT_ONE << depth_eff;
        block_done = (cnt_next == block_len);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc        <= '0;
            sample_cnt <= '0;
            depth_last <= '0;
            avg_valid  <= 1'b0;
            avg_value  <= '0;
        end else if (clear) begin
            acc        <= '0;
            sample_cnt <= '0;
            depth_last <= '0;
            avg_valid  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (sample_valid) begin
                depth_last <= depth_eff;
                if (block_done) begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    avg_valid  <= 1'b1;
                    avg_value  <= RATE_COUNTER_WIDTH'(acc_sum >> depth_eff);
                end else begin
                    acc        <= acc_sum;
                    sample_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: rtl/clks_alot_half_rate_meter.sv
// Measures high/low half-periods from recovered edge pulses and flags band violations.
// Optional block averaging of the rates is enabled with CLKS_ALOT_RATE_AVERAGING_EN.
module clks_alot_half_rate_meter
    import clks_alot_p::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable_i,
    input  recovered_events_s     events_i,
    input  half_rate_limits_s     high_limits_i,
    input  half_rate_limits_s     low_limits_i,
    output recovered_half_rates_s rates_o,
    output logic                  high_rate_valid_o,
    output logic                  low_rate_valid_o
);

    localparam logic [RATE_COUNTER_WIDTH-1:0] COUNT_ONE = RATE_COUNTER_WIDTH'(1);
    localparam logic [RATE_COUNTER_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [RATE_COUNTER_WIDTH:0]   WIDE_ONE  = (RATE_COUNTER_WIDTH+1)'(1);

    meter_state_e                  state;
    meter_state_e                  state_next;
    logic [RATE_COUNTER_WIDTH-1:0] phase_count;
    logic                          rise_only;
    logic                          fall_only;
    logic                          edge_accepted;
    logic                          take_high;
    logic                          take_low;
    logic                          take_any;
    half_rate_limits_s             active_limits;
    logic                          over_hit;
    logic                          under_hit;
    logic                          high_update;
    logic                          low_update;
    logic [RATE_COUNTER_WIDTH-1:0] high_value;
    logic [RATE_COUNTER_WIDTH-1:0] low_value;

    // Simultaneous edges are ambiguous and are dropped before the FSM sees them.
    always_comb begin
        rise_only     = events_i.rising_edge & ~events_i.falling_edge;
        fall_only     = events_i.falling_edge & ~events_i.rising_edge;
        state_next    = state;
        edge_accepted = 1'b0;
        take_high     = 1'b0;
        take_low      = 1'b0;
        case (state)
            IDLE: begin
                if (rise_only) begin
                    state_next    = MEAS_HIGH;
                    edge_accepted = 1'b1;
                end else if (fall_only) begin
                    state_next    = MEAS_LOW;
                    edge_accepted = 1'b1;
                end
            end
            MEAS_HIGH: begin
                if (fall_only) begin
                    take_high     = 1'b1;
                    state_next    = MEAS_LOW;
                    edge_accepted = 1'b1;
                end else if (rise_only) begin
                    edge_accepted = 1'b1;
                end
            end
            MEAS_LOW: begin
                if (rise_only) begin
                    take_low      = 1'b1;
                    state_next    = MEAS_HIGH;
                    edge_accepted = 1'b1;
                end else if (fall_only) begin
                    edge_accepted = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        take_any      = take_high | take_low;
        active_limits = take_high ? high_limits_i : low_limits_i;
        over_hit      = (phase_count <= active_limits.minimum_band_minus_one);
        // Widened compare so a maximum limit of all-ones cannot wrap.
        under_hit     = ({1'b0, phase_count} >
                         ({1'b0, active_limits.maximum_band_minus_one} + WIDE_ONE))
                        || (phase_count == COUNT_MAX);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            phase_count <= '0;
        end else if (!enable_i) begin
            state       <= IDLE;
            phase_count <= '0;
        end else begin
            state <= state_next;
            if (edge_accepted)
                phase_count <= COUNT_ONE;
            else if (phase_count != COUNT_MAX)
                phase_count <= phase_count + COUNT_ONE;
        end
    end

`ifdef CLKS_ALOT_RATE_AVERAGING_EN
    logic                          high_avg_valid;
    logic                          low_avg_valid;
    logic [RATE_COUNTER_WIDTH-1:0] high_avg;
    logic [RATE_COUNTER_WIDTH-1:0] low_avg;

    clks_alot_rate_averager u_high_avg (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .clear        (~enable_i),
        .sample_valid (enable_i & take_high),
        .sample       (phase_count),
        .depth        (high_limits_i.rate_averaging_depth),
        .avg_valid    (high_avg_valid),
        .avg_value    (high_avg)
    );

    clks_alot_rate_averager u_low_avg (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .clear        (~enable_i),
        .sample_valid (enable_i & take_low),
        .sample       (phase_count),
        .depth        (low_limits_i.rate_averaging_depth),
        .avg_valid    (low_avg_valid),
        .avg_value    (low_avg)
    );

    assign high_update = enable_i & high_avg_valid;
    assign low_update  = enable_i & low_avg_valid;
    assign high_value  = high_avg;
    assign low_value   = low_avg;
`else
    logic unused_depth;

    assign unused_depth = ^{high_limits_i.rate_averaging_depth, low_limits_i.rate_averaging_depth};
    assign high_update  = enable_i & take_high;
    assign low_update   = enable_i & take_low;
    assign high_value   = phase_count;
    assign low_value    = phase_count;
`endif

    // Violations always judge the raw sample; rates hold while disabled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rates_o           <= '0;
            high_rate_valid_o <= 1'b0;
            low_rate_valid_o  <= 1'b0;
        end else begin
            rates_o.over_frequency_violation  <= enable_i & take_any & over_hit;
            rates_o.under_frequency_violation <= enable_i & take_any & under_hit;
            high_rate_valid_o                 <= high_update;
            low_rate_valid_o                  <= low_update;
            if (high_update)
                rates_o.high_rate <= high_value;
            if (low_update)
                rates_o.low_rate <= low_value;
        end
    end

endmodule

// File: tb/tb_clks_alot_half_rate_meter.sv
// Bench for clks_alot_half_rate_meter: vector table, corner sequences and random
// edges checked against a cycle-stamped edge model (averaging when CLKS_ALOT_RATE_AVERAGING_EN).
module tb_clks_alot_half_rate_meter;
    import clks_alot_p::*;

    localparam int M_IDLE = 0;
    localparam int M_HIGH = 1;
    localparam int M_LOW  = 2;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b1;
    logic                  enable = 1'b0;
    recovered_events_s     events = '0;
    half_rate_limits_s     high_lim = '0;
    half_rate_limits_s     low_lim = '0;
    recovered_half_rates_s rates_o;
    logic                  high_rate_valid_o;
    logic                  low_rate_valid_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    // scoreboard: {due cycle, value} and {due cycle, over, under}
    logic [63:0] exp_hi_q[$];
    logic [63:0] exp_lo_q[$];
    logic [33:0] exp_viol_q[$];
    logic [31:0] m_high = '0;
    logic [31:0] m_low = '0;
    int          m_state = M_IDLE;
    int unsigned last_edge = 0;
    longint unsigned blk_sum[2];
    int          blk_n[2];
    int          blk_d[2];

    // observed tallies for the table and corner sequences
    logic [31:0] obs_high, obs_low;
    int          hv_cnt, lv_cnt, over_cnt, under_cnt;

    typedef struct {
        int          high_len;
        int          low_len;
        logic [31:0] min_m1;
        logic [31:0] max_m1;
        logic [31:0] exp_high;
        logic [31:0] exp_low;
        int          exp_over;
        int          exp_under;
    } vec_t;

    vec_t vecs[7];

    clks_alot_half_rate_meter dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .enable_i          (enable),
        .events_i          (events),
        .high_limits_i     (high_lim),
        .low_limits_i      (low_lim),
        .rates_o           (rates_o),
        .high_rate_valid_o (high_rate_valid_o),
        .low_rate_valid_o  (low_rate_valid_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_hi_q.delete();
        exp_lo_q.delete();
        exp_viol_q.delete();
        m_high  = '0;
        m_low   = '0;
        m_state = M_IDLE;
        for (int p = 0; p < 2; p++) begin
            blk_sum[p] = 0;
            blk_n[p]   = 0;
            blk_d[p]   = 0;
        end
    endtask

    task automatic model_sample(input int phase, input int unsigned s);
        half_rate_limits_s lim;
        bit                over, under;
        int                d;
        lim   = (phase == 0) ? high_lim : low_lim;
        over  = (s <= lim.minimum_band_minus_one);
        under = (longint'(s) > longint'(lim.maximum_band_minus_one) + 1);
        if (over || under)
            exp_viol_q.push_back({cyc, over, under});
`ifdef CLKS_ALOT_RATE_AVERAGING_EN
        d = (lim.rate_averaging_depth > 10) ? 10 : int'(lim.rate_averaging_depth);
        if (d != blk_d[phase]) begin
            blk_sum[phase] = 0;
            blk_n[phase]   = 0;
            blk_d[phase]   = d;
        end
        blk_sum[phase] += s;
        blk_n[phase]++;
        if (blk_n[phase] == (1 << d)) begin
            if (phase == 0) exp_hi_q.push_back({cyc + 1, 32'(blk_sum[phase] >> d)});
            else            exp_lo_q.push_back({cyc + 1, 32'(blk_sum[phase] >> d)});
            blk_sum[phase] = 0;
            blk_n[phase]   = 0;
        end
`else
        d = 0;
        if (phase == 0) exp_hi_q.push_back({cyc, s});
        else            exp_lo_q.push_back({cyc, s});
`endif
    endtask

    // Edges sampled at clock number cyc; a half-period is the distance in clocks
    // between the accepted edge that opened it and the opposite edge that closes it.
    task automatic model_step(input bit r, input bit f);
        bit          ar, af;
        int unsigned s;
        ar = r & ~f;
        af = f & ~r;
        s  = cyc - last_edge;
        if (!enable) begin
            m_state = M_IDLE;
            for (int p = 0; p < 2; p++) begin
                blk_sum[p] = 0;
                blk_n[p]   = 0;
                blk_d[p]   = 0;
            end
            while (exp_hi_q.size() > 0 && exp_hi_q[0][63:32] <= cyc) void'(exp_hi_q.pop_front());
            while (exp_lo_q.size() > 0 && exp_lo_q[0][63:32] <= cyc) void'(exp_lo_q.pop_front());
            return;
        end
        if (m_state == M_IDLE) begin
            if (ar)      begin m_state = M_HIGH; last_edge = cyc; end
            else if (af) begin m_state = M_LOW;  last_edge = cyc; end
        end else if (m_state == M_HIGH) begin
            if (af)      begin model_sample(0, s); m_state = M_LOW; last_edge = cyc; end
            else if (ar) last_edge = cyc;
        end else begin
            if (ar)      begin model_sample(1, s); m_state = M_HIGH; last_edge = cyc; end
            else if (af) last_edge = cyc;
        end
    endtask

    task automatic check_outputs();
        bit          ev;
        logic [33:0] vh;
        ev = (exp_hi_q.size() > 0) && (exp_hi_q[0][63:32] == cyc);
        chk("high_valid", 32'(high_rate_valid_o), 32'(ev));
        if (ev) begin m_high = exp_hi_q[0][31:0]; void'(exp_hi_q.pop_front()); end
        chk("high_rate", rates_o.high_rate, m_high);
        ev = (exp_lo_q.size() > 0) && (exp_lo_q[0][63:32] == cyc);
        chk("low_valid", 32'(low_rate_valid_o), 32'(ev));
        if (ev) begin m_low = exp_lo_q[0][31:0]; void'(exp_lo_q.pop_front()); end
        chk("low_rate", rates_o.low_rate, m_low);
        vh = 34'b0;
        if (exp_viol_q.size() > 0 && exp_viol_q[0][33:2] == cyc) begin
            vh = exp_viol_q[0];
            void'(exp_viol_q.pop_front());
        end
        chk("over_viol", 32'(rates_o.over_frequency_violation), 32'(vh[1]));
        chk("under_viol", 32'(rates_o.under_frequency_violation), 32'(vh[0]));
        if (high_rate_valid_o) begin hv_cnt++; obs_high = rates_o.high_rate; end
        if (low_rate_valid_o)  begin lv_cnt++; obs_low = rates_o.low_rate; end
        if (rates_o.over_frequency_violation)  over_cnt++;
        if (rates_o.under_frequency_violation) under_cnt++;
    endtask

    task automatic step(input bit r, input bit f);
        events.rising_edge  = r;
        events.falling_edge = f;
        @(posedge sys_clk);
        #1;
        cyc++;
        model_step(r, f);
        check_outputs();
        events = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic clear_tally();
        obs_high = '0; obs_low = '0;
        hv_cnt = 0; lv_cnt = 0; over_cnt = 0; under_cnt = 0;
    endtask

    task automatic set_limits(input logic [31:0] mn, input logic [31:0] mx,
                              input logic [3:0] hd, input logic [3:0] ld);
        high_lim = '{minimum_band_minus_one: mn, maximum_band_minus_one: mx, rate_averaging_depth: hd};
        low_lim  = '{minimum_band_minus_one: mn, maximum_band_minus_one: mx, rate_averaging_depth: ld};
    endtask

    task automatic disable_pause();
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_high_rate"}, rates_o.high_rate, 32'd0);
        chk({tag, "_low_rate"}, rates_o.low_rate, 32'd0);
        chk({tag, "_viol"}, {30'd0, rates_o.over_frequency_violation, rates_o.under_frequency_violation}, 32'd0);
        chk({tag, "_high_valid"}, 32'(high_rate_valid_o), 32'd0);
        chk({tag, "_low_valid"}, 32'(low_rate_valid_o), 32'd0);
    endtask

    initial begin
        bit r, f;
        vecs[0] = '{10, 6,  32'd3, 32'd19, 32'd10, 32'd6,  0, 0};
        vecs[1] = '{5,  8,  32'd5, 32'd19, 32'd5,  32'd8,  1, 0};
        vecs[2] = '{6,  8,  32'd5, 32'd19, 32'd6,  32'd8,  0, 0};
        vecs[3] = '{8,  11, 32'd3, 32'd9,  32'd8,  32'd11, 0, 1};
        vecs[4] = '{8,  10, 32'd3, 32'd9,  32'd8,  32'd10, 0, 0};
        vecs[5] = '{1,  1,  32'd0, 32'd0,  32'd1,  32'd1,  0, 0};
        vecs[6] = '{3,  25, 32'd3, 32'd19, 32'd3,  32'd25, 1, 1};

        model_reset();
        clear_tally();
        repeat (2) @(posedge sys_clk);
        #1;
        cyc += 2;
        check_all_zero("reset");
        sys_rst = 1'b0;

        // table vectors: one full period from IDLE, N=1
        foreach (vecs[k]) begin
            set_limits(vecs[k].min_m1, vecs[k].max_m1, 4'd0, 4'd0);
            enable = 1'b1;
            idle(1);
            clear_tally();
            step(1'b1, 1'b0);
            idle(vecs[k].high_len - 1);
            step(1'b0, 1'b1);
            idle(vecs[k].low_len - 1);
            step(1'b1, 1'b0);
            idle(3);
            chk($sformatf("vec%0d_high", k), obs_high, vecs[k].exp_high);
            chk($sformatf("vec%0d_low", k), obs_low, vecs[k].exp_low);
            chk($sformatf("vec%0d_hv_cnt", k), 32'(hv_cnt), 32'd1);
            chk($sformatf("vec%0d_lv_cnt", k), 32'(lv_cnt), 32'd1);
            chk($sformatf("vec%0d_over", k), 32'(over_cnt), 32'(vecs[k].exp_over));
            chk($sformatf("vec%0d_under", k), 32'(under_cnt), 32'(vecs[k].exp_under));
            disable_pause();
        end

        // repeated rising edge resyncs the high phase
        set_limits(32'd3, 32'd19, 4'd0, 4'd0);
        clear_tally();
        step(1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0);
        idle(6);
        step(1'b0, 1'b1);
        idle(3);
        chk("resync_high", obs_high, 32'd7);
        chk("resync_hv_cnt", 32'(hv_cnt), 32'd1);
        chk("resync_viol_cnt", 32'(over_cnt + under_cnt), 32'd0);
        disable_pause();

        // simultaneous edges are ignored, counter keeps running
        clear_tally();
        step(1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b1);
        idle(5);
        step(1'b0, 1'b1);
        idle(3);
        chk("both_high", obs_high, 32'd10);
        chk("both_hv_cnt", 32'(hv_cnt), 32'd1);
        disable_pause();

        // reset in the middle of a high phase
        step(1'b1, 1'b0);
        idle(4);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge sys_clk);
        #1;
        cyc++;
        sys_rst = 1'b0;
        clear_tally();
        idle(2);
        step(1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b0);
        idle(3);
        chk("midrst_hv_cnt", 32'(hv_cnt), 32'd0);
        chk("midrst_lv_cnt", 32'(lv_cnt), 32'd1);
        chk("midrst_low", obs_low, 32'd5);
        disable_pause();

`ifdef CLKS_ALOT_RATE_AVERAGING_EN
        // N=4 block over high phases 8..11
        set_limits(32'd3, 32'd19, 4'd2, 4'd0);
        clear_tally();
        step(1'b1, 1'b0);
        for (int h = 8; h <= 11; h++) begin
            idle(h - 1);
            step(1'b0, 1'b1);
            idle(4);
            if (h != 11) step(1'b1, 1'b0);
        end
        idle(3);
        chk("avg_hv_cnt", 32'(hv_cnt), 32'd1);
        chk("avg_high", obs_high, 32'd9);
        disable_pause();
`endif

        // random edges against the model
        for (int seg = 0; seg < 12; seg++) begin
            set_limits(32'($urandom_range(0, 8)), 32'($urandom_range(5, 20)),
                       (seg == 5) ? 4'd11 : 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)));
            for (int i = 0; i < 250; i++) begin
                int sel;
                enable = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 99) == 0) high_lim.rate_averaging_depth = 4'($urandom_range(0, 3));
                sel = $urandom_range(0, 99);
                r = (sel < 8) || (sel >= 16 && sel < 18);
                f = (sel >= 8 && sel < 18);
                step(r, f);
            end
        end
        enable = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clks_alot_half_rate_meter.md
CLKS_ALOT_HALF_RATE_METER -- requirements
Module: clks_alot_half_rate_meter

Interface
REQ-001 SHALL have no parameters; all widths come from clks_alot_p (RATE_COUNTER_WIDTH=32, MAX_AVG_DEPTH_WIDTH=10).
REQ-002 SHALL have these ports, clock and reset first:
  sys_clk  in  1  sole clock
  sys_rst  in  1  asynchronous, active-high reset
  enable_i  in  1  0 = hold in IDLE and clear accumulators
  events_i  in  recovered_events_s  edge pulses from the upstream recovery stage
  high_limits_i  in  half_rate_limits_s  high-phase band limits and averaging depth
  low_limits_i  in  half_rate_limits_s  low-phase band limits and averaging depth
  rates_o  out  recovered_half_rates_s  averaged high/low rates plus violation pulses
  high_rate_valid_o  out  1  one-cycle pulse when rates_o.high_rate updates
  low_rate_valid_o  out  1  one-cycle pulse when rates_o.low_rate updates

Function
REQ-003 SHALL run an FSM with states IDLE, MEAS_HIGH and MEAS_LOW.
REQ-004 IDLE: rising_edge -> MEAS_HIGH; falling_edge -> MEAS_LOW; no sample is taken on either.
REQ-005 MEAS_HIGH: falling_edge -> take a high sample, go to MEAS_LOW.
REQ-006 MEAS_LOW: rising_edge -> take a low sample, go to MEAS_HIGH.
REQ-007 A same-type edge (rising in MEAS_HIGH, falling in MEAS_LOW) SHALL resync: restart the phase counter, take no sample, raise no violation.
REQ-008 rising_edge and falling_edge asserted together SHALL be ignored; state and counter continue unchanged.
REQ-009 Phase counter (32b): loads 1 on the cycle after any accepted edge, +1 per cycle, saturates at 2^32-1; sample = counter value on the edge cycle.
REQ-010 Over-frequency: over_frequency_violation SHALL pulse when sample <= minimum_band_minus_one of the active phase's limits.
REQ-011 Under-frequency: under_frequency_violation SHALL pulse when sample > maximum_band_minus_one + 1, or when the counter is saturated.
REQ-012 Both violation checks SHALL use the raw sample, never the averaged value.
REQ-013 Each violation pulse SHALL last exactly one cycle, on the cycle after the edge.
REQ-014 Outputs SHALL be registered; rate/valid/violation updates occur 1 cycle after the edge cycle (without averaging).
REQ-015 enable_i low SHALL force IDLE and clear counter and accumulators; rates_o.high_rate and rates_o.low_rate hold their values.
REQ-016 enable_i low SHALL suppress all valid and violation pulses.

Reset
REQ-017 On sys_rst: FSM = IDLE, counter = 0, accumulators = 0, rates_o = all zeros, both valid outputs = 0.
REQ-018 Reset asserted mid-measurement SHALL discard the partial phase and any partial average.

Configuration
REQ-019 With CLKS_ALOT_RATE_AVERAGING_EN defined:
  - rate_averaging_depth is log2(N), clamped to 10.
  - each phase has its own accumulator (42b) and sample counter.
  - after N samples: rate output = accumulator >> log2(N), valid pulses one cycle later than without averaging, accumulator restarts.
REQ-020 A rate_averaging_depth change SHALL take effect at the next sample: that phase's accumulator and sample counter restart, and no valid pulse is issued for the partial block.
REQ-021 Without CLKS_ALOT_RATE_AVERAGING_EN: rate_averaging_depth is ignored; every sample drives the rate output and its valid pulse directly.

Structure
REQ-022 The FSM state enum and the accumulator width constant (RATE_COUNTER_WIDTH + MAX_AVG_DEPTH_WIDTH) SHALL live in clks_alot_p.
REQ-023 Block-averaging logic SHALL be one sub-module, clks_alot_rate_averager, instantiated once per phase.

Verification
REQ-024 Square wave with 10 high / 6 low cycles, limits 4..20, no averaging -> after the first full period, high_rate = 10 and low_rate = 6 per period; no violations.
REQ-025 Averaging on, depth 2 (N=4), high phases 8, 9, 10, 11 -> one high_rate_valid_o pulse with high_rate = 9 (38>>2).
REQ-026 minimum_band_minus_one = 5, high phase of 5 cycles -> over_frequency_violation pulses once; high phase of 6 -> no violation.
REQ-027 maximum_band_minus_one = 9: low phase of 11 cycles -> under_frequency_violation; low phase of 10 -> none.
REQ-028 Two rising edges with no falling edge between -> no sample and no violation; the next falling edge yields a high sample equal to the cycles since the second rising edge.
REQ-029 sys_rst pulse in the middle of MEAS_HIGH -> all outputs 0 on that cycle; the first edge after release only syncs and yields no valid pulse.
